// File: rtl/sy_ppl_ctrl_mc_if.sv
// Signal bundle between the pipeline controller and the core: events, PCs, stage activity,
// maintenance handshakes and fetch redirect outputs.
interface sy_ppl_ctrl_mc_if #(
  parameter int unsigned AWTH   = 64,
  parameter int unsigned NSTG   = 5,
  parameter int unsigned NMAINT = 3
);
  logic [AWTH-1:0]   boot_addr_i;
  logic              ctrl_reset_i;
  logic              ctrl_halt_i;
  logic [NSTG-1:0]   stg_act_i;
  logic              fu_act_i;
  logic              ev_excp_i;
  logic [AWTH-1:0]   trap_vec_i;
  logic              ev_eret_i;
  logic [AWTH-1:0]   epc_i;
  logic              ev_debug_i;
  logic [AWTH-1:0]   dbg_vec_i;
  logic              ev_flush_i;
  logic              ev_wfi_i;
  logic              wakeup_i;
  logic [NMAINT-1:0] maint_req_i;
  logic [AWTH-1:0]   wb_npc_i;
  logic [NMAINT-1:0] maint_ack_i;
  logic [NMAINT-1:0] maint_o;
  logic [NSTG-1:0]   kill_o;
  logic              fet_set_en_o;
  logic [AWTH-1:0]   fet_set_npc_o;
  logic              fet_act_o;
  logic              flush_bp_o;
  logic              stat_sleep_o;
  logic              stat_maint_err_o;

  modport master (
    output boot_addr_i, ctrl_reset_i, ctrl_halt_i, stg_act_i, fu_act_i,
    output ev_excp_i, trap_vec_i, ev_eret_i, epc_i, ev_debug_i, dbg_vec_i,
    output ev_flush_i, ev_wfi_i, wakeup_i, maint_req_i, wb_npc_i, maint_ack_i,
    input  maint_o, kill_o, fet_set_en_o, fet_set_npc_o, fet_act_o, flush_bp_o,
    input  stat_sleep_o, stat_maint_err_o
  );

  modport slave (
    input  boot_addr_i, ctrl_reset_i, ctrl_halt_i, stg_act_i, fu_act_i,
    input  ev_excp_i, trap_vec_i, ev_eret_i, epc_i, ev_debug_i, dbg_vec_i,
    input  ev_flush_i, ev_wfi_i, wakeup_i, maint_req_i, wb_npc_i, maint_ack_i,
    output maint_o, kill_o, fet_set_en_o, fet_set_npc_o, fet_act_o, flush_bp_o,
    output stat_sleep_o, stat_maint_err_o
  );
endinterface

// File: rtl/sy_ppl_ctrl_mc.sv
// Pipeline controller: run/pause FSM, fetch redirect on trap/xret/debug/flush/wfi, stage kill,
// WFI sleep and prioritised cache/TLB maintenance sequencing with ack timeout.
module sy_ppl_ctrl_mc #(
  parameter int unsigned       AWTH      = 64,
  parameter int unsigned       NSTG      = 5,
  parameter int unsigned       NMAINT    = 3,
  parameter logic [NMAINT-1:0] MAINT_ACK = 3'b011,
  parameter int unsigned       ACK_TO    = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  sy_ppl_ctrl_mc_if.slave bus
);

  typedef enum logic [2:0] {
    StReset, StInit, StProc, StRun, StPause, StMaint, StSleep
  } state_e;

  localparam logic [7:0] AckTo = 8'(ACK_TO);

  state_e            r_state, w_state_d;
  logic [AWTH-1:0]   r_pend_pc, w_pend_pc_d;
  logic [NMAINT-1:0] r_pend_mask, w_pend_mask_d;
  logic              r_pend_vld, w_pend_vld_d;
  logic              r_pend_excp, w_pend_excp_d;
  logic              r_pend_eret, w_pend_eret_d;
  logic              r_pend_dbg, w_pend_dbg_d;
  logic              r_pend_wfi, w_pend_wfi_d;
  logic [7:0]        r_ctr, w_ctr_d;
  logic              r_err, w_err_d;
  logic [NSTG-1:0]   r_kill;
  logic              r_set_en, w_set_en_d;
  logic [AWTH-1:0]   r_set_npc;
  logic              r_flush_bp, w_flush_bp_d;

  logic              w_idle, w_redir, w_cap;
  logic [AWTH-1:0]   w_cap_pc;
  logic [NMAINT-1:0] w_sel_oh, w_mask_clr;
  logic              w_sel_ack, w_sel_got, w_clr_pend;

  always_comb begin
    w_idle  = ~(|bus.stg_act_i) & ~bus.fu_act_i;
    w_redir = bus.ev_excp_i | bus.ev_eret_i | bus.ev_debug_i;
    w_cap   = w_redir | bus.ev_flush_i | bus.ev_wfi_i | (|bus.maint_req_i);
    if (bus.ev_excp_i) begin
      w_cap_pc = bus.trap_vec_i;
    end else if (bus.ev_eret_i) begin
      w_cap_pc = bus.epc_i;
    end else if (bus.ev_debug_i) begin
      w_cap_pc = bus.dbg_vec_i;
    end else begin
      w_cap_pc = bus.wb_npc_i;
    end
  end

  // Lowest set bit of the pending mask is the channel being served.
  assign w_sel_oh  = r_pend_mask & (~r_pend_mask + NMAINT'(1));
  assign w_sel_ack = |(w_sel_oh & MAINT_ACK);
  assign w_sel_got = |(w_sel_oh & bus.maint_ack_i);

  always_comb begin
    w_state_d    = r_state;
    w_ctr_d      = '0;
    w_err_d      = r_err;
    w_set_en_d   = 1'b0;
    w_flush_bp_d = 1'b0;
    w_clr_pend   = 1'b0;
    w_mask_clr   = '0;
    case (r_state)
      StReset: begin
        if (w_idle) begin
          w_state_d    = StInit;
          w_flush_bp_d = 1'b1;
        end
      end
      StInit: w_state_d = StProc;
      StProc: begin
        if (!bus.ctrl_halt_i) begin
          w_set_en_d   = 1'b1;
          w_flush_bp_d = r_pend_excp | r_pend_eret;
          w_clr_pend   = 1'b1;
          if (|r_pend_mask) begin
            w_state_d = StMaint;
          end else if (r_pend_wfi && !bus.ev_debug_i) begin
            w_state_d = StSleep;
          end else begin
            w_state_d = StRun;
          end
        end
      end
      StRun: begin
        if (bus.ctrl_halt_i || r_pend_vld || (|r_pend_mask) || w_cap) begin
          w_state_d = StPause;
        end
      end
      StPause: begin
        if (w_idle) begin
          w_state_d = StProc;
        end
      end
      StMaint: begin
        if (|r_pend_mask) begin
          if (!w_sel_ack || w_sel_got) begin
            w_mask_clr = w_sel_oh;
          end else if (r_ctr == AckTo) begin
            w_mask_clr = w_sel_oh;
            w_err_d    = 1'b1;
          end else begin
            w_ctr_d = (r_ctr == 8'hFF) ? r_ctr : r_ctr + 8'd1;
          end
        end
        if ((r_pend_mask & ~w_mask_clr) == '0) begin
          w_state_d = StProc;
        end
      end
      StSleep: begin
        if (bus.wakeup_i || w_cap) begin
          w_state_d = StProc;
        end
      end
      default: w_state_d = StReset;
    endcase
    if (bus.ctrl_reset_i) begin
      w_state_d    = StReset;
      w_set_en_d   = 1'b0;
      w_flush_bp_d = 1'b0;
      w_ctr_d      = '0;
    end
  end

  // Later captures accumulate; a redirect PC is not overwritten by a lower-priority wb_npc.
  always_comb begin
    w_pend_pc_d   = r_pend_pc;
    w_pend_mask_d = r_pend_mask & ~w_mask_clr;
    w_pend_vld_d  = r_pend_vld;
    w_pend_excp_d = r_pend_excp;
    w_pend_eret_d = r_pend_eret;
    w_pend_dbg_d  = r_pend_dbg;
    w_pend_wfi_d  = r_pend_wfi;
    if (w_clr_pend) begin
      w_pend_vld_d  = 1'b0;
      w_pend_excp_d = 1'b0;
      w_pend_eret_d = 1'b0;
      w_pend_dbg_d  = 1'b0;
      w_pend_wfi_d  = 1'b0;
    end
    if (w_cap) begin
      w_pend_vld_d = 1'b1;
      if (w_redir) begin
        w_pend_pc_d   = w_cap_pc;
        w_pend_excp_d = w_pend_excp_d | bus.ev_excp_i;
        w_pend_eret_d = w_pend_eret_d | bus.ev_eret_i;
        w_pend_dbg_d  = w_pend_dbg_d | bus.ev_debug_i;
        w_pend_wfi_d  = 1'b0;
      end else begin
        if (!(w_pend_excp_d || w_pend_eret_d || w_pend_dbg_d)) begin
          w_pend_pc_d = bus.wb_npc_i;
        end
        w_pend_wfi_d  = w_pend_wfi_d | bus.ev_wfi_i;
        w_pend_mask_d = w_pend_mask_d | bus.maint_req_i;
      end
    end else if (r_state == StInit) begin
      w_pend_pc_d = bus.boot_addr_i;
    end
    if (bus.ctrl_reset_i) begin
      w_pend_mask_d = '0;
      w_pend_vld_d  = 1'b0;
      w_pend_excp_d = 1'b0;
      w_pend_eret_d = 1'b0;
      w_pend_dbg_d  = 1'b0;
      w_pend_wfi_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StReset;
      r_pend_pc   <= '0;
      r_pend_mask <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_excp <= 1'b0;
      r_pend_eret <= 1'b0;
      r_pend_dbg  <= 1'b0;
      r_pend_wfi  <= 1'b0;
      r_ctr       <= '0;
      r_err       <= 1'b0;
      r_kill      <= '0;
      r_set_en    <= 1'b0;
      r_set_npc   <= '0;
      r_flush_bp  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pend_pc   <= w_pend_pc_d;
      r_pend_mask <= w_pend_mask_d;
      r_pend_vld  <= w_pend_vld_d;
      r_pend_excp <= w_pend_excp_d;
      r_pend_eret <= w_pend_eret_d;
      r_pend_dbg  <= w_pend_dbg_d;
      r_pend_wfi  <= w_pend_wfi_d;
      r_ctr       <= w_ctr_d;
      r_err       <= w_err_d;
      r_kill      <= {NSTG{w_cap}};
      r_set_en    <= w_set_en_d;
      if (w_set_en_d) begin
        r_set_npc <= r_pend_pc;
      end
      r_flush_bp  <= w_flush_bp_d;
    end
  end

  assign bus.maint_o          = (r_state == StMaint) ? w_sel_oh : '0;
  assign bus.kill_o           = r_kill;
  assign bus.fet_set_en_o     = r_set_en;
  assign bus.fet_set_npc_o    = r_set_npc;
  assign bus.fet_act_o        = (r_state == StRun);
  assign bus.flush_bp_o       = r_flush_bp;
  assign bus.stat_sleep_o     = (r_state == StSleep);
  assign bus.stat_maint_err_o = r_err;

endmodule

// File: tb/tb_sy_ppl_ctrl_mc.sv
// Directed bench for sy_ppl_ctrl_mc: boot, trap vs fence.i, maintenance sequencing, ack timeout,
// WFI sleep/wakeup and soft reset during maintenance.
module tb_sy_ppl_ctrl_mc;
  localparam int unsigned AWTH   = 64;
  localparam int unsigned NSTG   = 5;
  localparam int unsigned NMAINT = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  sy_ppl_ctrl_mc_if #(.AWTH(AWTH), .NSTG(NSTG), .NMAINT(NMAINT)) pif ();

  sy_ppl_ctrl_mc #(
    .AWTH(AWTH), .NSTG(NSTG), .NMAINT(NMAINT), .MAINT_ACK(3'b011), .ACK_TO(255)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (pif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_set(input int bound, input string tag);
    int n = 0;
    while (!pif.fet_set_en_o && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(pif.fet_set_en_o), 64'd1);
  endtask

  task automatic wait_maint(input int bound, input string tag);
    int n = 0;
    while (pif.maint_o == '0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(pif.maint_o != '0), 64'd1);
  endtask

  initial begin
    int          n;
    logic        mseen, fseen;
    logic [63:0] npc;

    rst = 1'b1;
    pif.boot_addr_i  = 64'h8000_0000;
    pif.ctrl_reset_i = 1'b0;
    pif.ctrl_halt_i  = 1'b0;
    pif.stg_act_i    = '0;
    pif.fu_act_i     = 1'b0;
    pif.ev_excp_i    = 1'b0;
    pif.trap_vec_i   = '0;
    pif.ev_eret_i    = 1'b0;
    pif.epc_i        = '0;
    pif.ev_debug_i   = 1'b0;
    pif.dbg_vec_i    = '0;
    pif.ev_flush_i   = 1'b0;
    pif.ev_wfi_i     = 1'b0;
    pif.wakeup_i     = 1'b0;
    pif.maint_req_i  = '0;
    pif.wb_npc_i     = '0;
    pif.maint_ack_i  = '0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_kill", 64'(pif.kill_o), 64'd0);
    chk("rst_set_en", 64'(pif.fet_set_en_o), 64'd0);
    chk("rst_fet_act", 64'(pif.fet_act_o), 64'd0);
    chk("rst_maint", 64'(pif.maint_o), 64'd0);
    chk("rst_flush_bp", 64'(pif.flush_bp_o), 64'd0);
    chk("rst_sleep_err", 64'({pif.stat_sleep_o, pif.stat_maint_err_o}), 64'd0);
    rst = 1'b0;

    // Boot
    @(negedge clk);
    chk("boot_flush_bp", 64'(pif.flush_bp_o), 64'd1);
    wait_set(4, "boot_set_en");
    chk("boot_npc", pif.fet_set_npc_o, 64'h8000_0000);
    chk("boot_fet_act", 64'(pif.fet_act_o), 64'd1);
    @(negedge clk);
    chk("boot_set_pulse", 64'(pif.fet_set_en_o), 64'd0);

    // Trap and fence.i in the same cycle: redirect wins, no maintenance
    pif.ev_excp_i   = 1'b1;
    pif.trap_vec_i  = 64'h100;
    pif.maint_req_i = 3'b001;
    pif.wb_npc_i    = 64'h999;
    @(negedge clk);
    pif.ev_excp_i   = 1'b0;
    pif.maint_req_i = '0;
    chk("trap_kill", 64'(pif.kill_o), 64'h1F);
    mseen = (pif.maint_o != '0);
    @(negedge clk);
    chk("trap_kill_pulse", 64'(pif.kill_o), 64'd0);
    fseen = 1'b0;
    npc   = '0;
    for (int i = 0; i < 8; i++) begin
      if (pif.maint_o != '0) mseen = 1'b1;
      if (pif.flush_bp_o) fseen = 1'b1;
      if (pif.fet_set_en_o) npc = pif.fet_set_npc_o;
      @(negedge clk);
    end
    chk("trap_no_maint", 64'(mseen), 64'd0);
    chk("trap_flush_bp", 64'(fseen), 64'd1);
    chk("trap_npc", npc, 64'h100);
    chk("trap_resume", 64'(pif.fet_act_o), 64'd1);

    // All three channels; unserved acks ignored; channels back-to-back
    pif.maint_req_i = 3'b111;
    pif.wb_npc_i    = 64'h2000;
    @(negedge clk);
    pif.maint_req_i = '0;
    wait_maint(6, "m3_start");
    chk("m3_ch0", 64'(pif.maint_o), 64'b001);
    pif.maint_ack_i = 3'b110;
    @(negedge clk);
    pif.maint_ack_i = '0;
    chk("m3_ch0_ignore_ack", 64'(pif.maint_o), 64'b001);
    repeat (3) @(negedge clk);
    chk("m3_ch0_hold", 64'(pif.maint_o), 64'b001);
    pif.maint_ack_i = 3'b001;
    @(negedge clk);
    pif.maint_ack_i = '0;
    chk("m3_ch1", 64'(pif.maint_o), 64'b010);
    @(negedge clk);
    chk("m3_ch1_hold", 64'(pif.maint_o), 64'b010);
    pif.maint_ack_i = 3'b010;
    @(negedge clk);
    pif.maint_ack_i = '0;
    chk("m3_ch2", 64'(pif.maint_o), 64'b100);
    @(negedge clk);
    chk("m3_ch2_pulse", 64'(pif.maint_o), 64'b000);
    wait_set(3, "m3_set_en");
    chk("m3_npc", pif.fet_set_npc_o, 64'h2000);
    chk("m3_no_err", 64'(pif.stat_maint_err_o), 64'd0);

    // Ack timeout on channel 1
    @(negedge clk);
    pif.maint_req_i = 3'b010;
    pif.wb_npc_i    = 64'h3000;
    @(negedge clk);
    pif.maint_req_i = '0;
    wait_maint(6, "to_start");
    n = 0;
    while (pif.maint_o == 3'b010 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("to_high_cycles", 64'(n), 64'd256);
    chk("to_err", 64'(pif.stat_maint_err_o), 64'd1);
    wait_set(4, "to_resume_set");
    chk("to_resume_npc", pif.fet_set_npc_o, 64'h3000);
    chk("to_resume_act", 64'(pif.fet_act_o), 64'd1);

    // WFI, with the pipeline busy for a while before it drains
    @(negedge clk);
    pif.ev_wfi_i = 1'b1;
    pif.wb_npc_i = 64'h204;
    pif.fu_act_i = 1'b1;
    @(negedge clk);
    pif.ev_wfi_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("wfi_pause_busy", 64'({pif.stat_sleep_o, pif.fet_set_en_o}), 64'd0);
    pif.fu_act_i = 1'b0;
    n = 0;
    while (!pif.stat_sleep_o && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("wfi_sleep", 64'(pif.stat_sleep_o), 64'd1);
    repeat (20) @(negedge clk);
    chk("wfi_still_sleep", 64'({pif.stat_sleep_o, pif.fet_act_o}), 64'b10);
    pif.wakeup_i = 1'b1;
    @(negedge clk);
    pif.wakeup_i = 1'b0;
    wait_set(4, "wfi_wake_set");
    chk("wfi_wake_npc", pif.fet_set_npc_o, 64'h204);
    chk("wfi_wake_act", 64'(pif.fet_act_o), 64'd1);
    chk("wfi_awake", 64'(pif.stat_sleep_o), 64'd0);

    // Soft reset in the middle of maintenance
    @(negedge clk);
    pif.boot_addr_i = 64'h9000_0000;
    pif.maint_req_i = 3'b010;
    pif.wb_npc_i    = 64'h4000;
    @(negedge clk);
    pif.maint_req_i = '0;
    wait_maint(6, "cr_maint_start");
    repeat (3) @(negedge clk);
    pif.ctrl_reset_i = 1'b1;
    @(negedge clk);
    pif.ctrl_reset_i = 1'b0;
    chk("cr_maint_drop", 64'(pif.maint_o), 64'd0);
    chk("cr_fet_off", 64'(pif.fet_act_o), 64'd0);
    wait_set(6, "cr_reboot_set");
    chk("cr_reboot_npc", pif.fet_set_npc_o, 64'h9000_0000);
    mseen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pif.maint_o != '0) mseen = 1'b1;
    end
    chk("cr_pend_cleared", 64'(mseen), 64'd0);
    chk("cr_running", 64'(pif.fet_act_o), 64'd1);
    chk("cr_err_sticky", 64'(pif.stat_maint_err_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
